// File: rtl/apb_xfer_sequencer.sv
// rtl/apb_xfer_sequencer.sv - round-robin APB4 master serialising single transfers from NUM_REQ requesters
// Optional watchdog on stalled ACCESS phases: define APB_SEQ_TIMEOUT_EN.
module apb_xfer_sequencer #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][3:0]  req_strb,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     timeout,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic [3:0]               PSTRB,
  output logic                     PSEL,
  output logic                     PENABLE,
  input  logic [31:0]              PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERROR
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic [3:0]         pstrb_q, pstrb_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               wdt_abort;

  // Search starts just after the previous owner so every requester is served within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[IDX_W'((int'(last_grant_q) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_found) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (PREADY || wdt_abort) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = '0;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    pwrite_d     = pwrite_q;
    pstrb_d      = pstrb_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          paddr_d      = req_addr[grant_idx];
          pwdata_d     = req_wdata[grant_idx];
          pwrite_d     = req_write[grant_idx];
          pstrb_d      = req_write[grant_idx] ? req_strb[grant_idx] : 4'h0;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          last_grant_d = grant_idx;
        end
      end
      S_SETUP: penable_d = 1'b1;
      S_ACCESS: begin
        // A slave response in the same cycle as the watchdog limit takes precedence.
        if (PREADY || wdt_abort) begin
          rsp_valid_d[last_grant_q] = 1'b1;
          rsp_err_d   = PREADY ? PSLVERROR : 1'b1;
          rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : 32'h0;
          paddr_d     = 32'h0;
          pwdata_d    = 32'h0;
          pwrite_d    = 1'b0;
          pstrb_d     = 4'h0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      paddr_q      <= 32'h0;
      pwdata_q     <= 32'h0;
      pwrite_q     <= 1'b0;
      pstrb_q      <= 4'h0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      pwrite_q     <= pwrite_d;
      pstrb_q      <= pstrb_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam logic [7:0] WDT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wdt_cnt_q;
  logic       timeout_q;

  assign wdt_abort = (state_q == S_ACCESS) && !PREADY && (wdt_cnt_q == WDT_LIMIT);

  // Counts ACCESS cycles with PREADY low; cleared while in SETUP so each ACCESS starts at zero.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wdt_cnt_q <= 8'h0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wdt_abort;
      if (state_q == S_SETUP) begin
        wdt_cnt_q <= 8'h0;
      end else if ((state_q == S_ACCESS) && !PREADY && !wdt_abort) begin
        wdt_cnt_q <= wdt_cnt_q + 8'd1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wdt_abort = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign PSTRB     = pstrb_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// tb/tb_apb_xfer_sequencer.sv - directed vector bench for apb_xfer_sequencer with NUM_REQ=3
module tb_apb_xfer_sequencer;

  logic              HCLK;
  logic              HRESETn;
  logic [2:0]        req_valid;
  logic [2:0][31:0]  req_addr;
  logic [2:0][31:0]  req_wdata;
  logic [2:0]        req_write;
  logic [2:0][3:0]   req_strb;
  logic [2:0]        req_ready;
  logic [2:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic              timeout;
  logic [31:0]       PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic [3:0]        PSTRB;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERROR;

  int checks;
  int failures;

  apb_xfer_sequencer #(.NUM_REQ(3), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_write(req_write), .req_strb(req_strb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .timeout(timeout),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
    .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  // Called at the negedge of an IDLE cycle T; returns at the negedge of T+3+waits.
  task automatic run_xfer(input vec_t v);
    logic [2:0] oh;
    oh = 3'b001 << v.req;
    req_valid          = oh;
    req_addr[v.req]    = v.addr;
    req_wdata[v.req]   = v.wdata;
    req_write[v.req]   = v.write;
    req_strb[v.req]    = v.strb;
    PREADY             = 1'b0;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(oh));
    tick();
    req_valid       = '0;
    req_addr[v.req] = ~v.addr;
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_paddr", PADDR, v.addr);
    chk("setup_pwdata", PWDATA, v.wdata);
    chk("setup_pwrite", 32'(PWRITE), 32'(v.write));
    chk("setup_pstrb", 32'(PSTRB), 32'(v.exp_pstrb));
    tick();
    chk("access_penable", 32'(PENABLE), 32'd1);
    for (int k = 0; k < v.waits; k++) begin
      PREADY = 1'b0;
      PRDATA = 32'hAAAA_5555;
      chk("wait_pstrb", 32'(PSTRB), 32'(v.exp_pstrb));
      chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    PREADY    = 1'b1;
    PRDATA    = v.prdata;
    PSLVERROR = v.slverr;
    tick();
    PREADY    = 1'b0;
    PSLVERROR = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
    chk("done_psel", 32'(PSEL), 32'd0);
    chk("done_paddr", PADDR, 32'd0);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen_rsp;
    checks    = 0;
    failures  = 0;
    seen_rsp  = 1'b0;
    HRESETn   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_write = '0;
    req_strb  = '0;
    PRDATA    = 32'h0;
    PREADY    = 1'b0;
    PSLVERROR = 1'b0;

    vecs[0] = '{2'd0, 1'b0, 32'h4000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 4'h0};
    vecs[1] = '{2'd2, 1'b0, 32'h4000_0020, 32'h7777_7777, 4'hF, 1, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0, 4'h0};
    vecs[2] = '{2'd0, 1'b1, 32'h4000_0030, 32'hCAFE_BABE, 4'hF, 0, 32'h9999_9999, 1'b0, 32'h0, 1'b0, 4'hF};
    vecs[3] = '{2'd1, 1'b1, 32'h4000_0004, 32'h1234_5678, 4'h3, 3, 32'hAAAA_5555, 1'b1, 32'h0, 1'b1, 4'h3};

    repeat (2) @(negedge HCLK);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    HRESETn = 1'b1;
    tick();
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);

    for (int i = 0; i < 4; i++) run_xfer(vecs[i]);

    // last owner is req1, so req2 wins first and req1 waits while its address changes
    req_valid    = 3'b110;
    req_write    = '0;
    req_addr[2]  = 32'h4000_0100;
    req_addr[1]  = 32'h4000_0200;
    PREADY       = 1'b1;
    PRDATA       = 32'h0000_0222;
    #1;
    chk("stable_first_grant", 32'(req_ready), 32'b100);
    tick();
    req_valid[2] = 1'b0;
    req_addr[1]  = 32'h4000_0204;
    chk("stable_req2_paddr", PADDR, 32'h4000_0100);
    tick();
    req_addr[1]  = 32'h4000_0208;
    tick();
    chk("stable_rsp2", 32'(rsp_valid), 32'b100);
    chk("stable_grant1_with_rsp", 32'(req_ready), 32'b010);
    chk("stable_rdata2", rsp_rdata, 32'h0000_0222);
    PRDATA       = 32'h0000_0333;
    tick();
    req_valid    = '0;
    req_addr[1]  = 32'h4000_DEAD;
    chk("stable_rsp_pulse", 32'(rsp_valid), 32'd0);
    chk("stable_rdata_held", rsp_rdata, 32'h0000_0222);
    chk("stable_req1_paddr", PADDR, 32'h4000_0208);
    tick();
    chk("stable_req1_paddr_access", PADDR, 32'h4000_0208);
    tick();
    chk("stable_rsp1", 32'(rsp_valid), 32'b010);
    chk("stable_rdata1", rsp_rdata, 32'h0000_0333);

    req_valid   = 3'b010;
    req_addr[1] = 32'h4000_0300;
    PREADY      = 1'b0;
    tick();
    req_valid   = '0;
    tick();
    tick();
    chk("midrst_psel_before", 32'(PSEL), 32'd1);
    chk("midrst_penable_before", 32'(PENABLE), 32'd1);
    HRESETn = 1'b0;
    #1;
    chk("midrst_psel", 32'(PSEL), 32'd0);
    chk("midrst_penable", 32'(PENABLE), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    PREADY = 1'b1;
    tick();
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    HRESETn = 1'b1;
    tick();
    chk("midrst_no_rsp_after", 32'(rsp_valid), 32'd0);

    req_valid = 3'b111;
    req_addr  = {32'h4000_0C00, 32'h4000_0B00, 32'h4000_0A00};
    PREADY    = 1'b1;
    PRDATA    = 32'h1111_2222;
    for (int g = 0; g < 6; g++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(3'b001 << (g % 3)));
      if (g > 0) chk("rr_rsp", 32'(rsp_valid), 32'(3'b001 << ((g - 1) % 3)));
      tick();
      chk("rr_no_grant_setup", 32'(req_ready), 32'd0);
      tick();
      chk("rr_no_grant_access", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;

    req_valid   = 3'b001;
    req_write   = '0;
    req_addr[0] = 32'h4000_0040;
    PREADY      = 1'b0;
    PRDATA      = 32'h5A5A_5A5A;
    #1;
    chk("to_grant", 32'(req_ready), 32'b001);
`ifdef APB_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 6; k++) begin
      tick();
      req_valid = '0;
      chk("to_early_timeout", 32'(timeout), 32'd0);
      chk("to_early_rsp", 32'(rsp_valid), 32'd0);
    end
    tick();
    chk("to_timeout", 32'(timeout), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_valid", 32'(rsp_valid), 32'b001);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", 32'(PSEL), 32'd0);
    tick();
    chk("to_timeout_pulse", 32'(timeout), 32'd0);
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      req_valid = '0;
      if (rsp_valid != 3'b000 || timeout) seen_rsp = 1'b1;
    end
    chk("nto_no_rsp", 32'(seen_rsp), 32'd0);
    chk("nto_psel", 32'(PSEL), 32'd1);
    chk("nto_penable", 32'(PENABLE), 32'd1);
    chk("nto_busy", 32'(busy), 32'd1);
    PREADY = 1'b1;
    tick();
    chk("nto_rsp_valid", 32'(rsp_valid), 32'b001);
    chk("nto_rsp_rdata", rsp_rdata, 32'h5A5A_5A5A);
    chk("nto_timeout", 32'(timeout), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
